// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blink_pkg
// Purpose  : Shared types and constants for the blink monitor slice.
// Revision : 1.0 - initial release
// ============================================================================
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } blink_mon_state_t;

    localparam int c_cnt_w_default        = 8;
    localparam int c_blink_interval_long  = 10;
    localparam int c_blink_interval_short = 5;

endpackage : blink_pkg
`default_nettype wire

// File: rtl/blink_monitor_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : blink_edge_detect
// Purpose  : Registers the previous input level and flags rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module blink_edge_detect #(
    parameter logic PREV_RST = 1'b1
) (
    input  logic clk,
    input  logic rstbtn,
    input  logic blink_in,
    output logic blink_edge
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rstbtn) begin
            r_prev <= PREV_RST;
        end else begin
            r_prev <= blink_in;
        end
    end

    assign blink_edge = blink_in & ~r_prev;

endmodule : blink_edge_detect
`default_nettype wire

// File: rtl/blink_monitor.sv
`default_nettype none
// ============================================================================
// Module   : blink_monitor
// Purpose  : Measures blink edge-to-edge intervals and tracks lock/mismatch.
//            Define BLINK_MONITOR_STATS_EN to build min/max interval stats.
// Revision : 1.0 - initial release
// ============================================================================
module blink_monitor
    import blink_pkg::*;
#(
    parameter int CNT_W      = c_cnt_w_default,
    parameter int LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             rstbtn,
    input  logic             blink_in,
    input  logic [CNT_W-1:0] exp_interval,
    output logic [CNT_W-1:0] interval_out,
    output logic             interval_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             overflow,
    output logic [CNT_W-1:0] min_interval,
    output logic [CNT_W-1:0] max_interval
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [3:0]       c_lock    = 4'(LOCK_COUNT);

    blink_mon_state_t r_state, w_state_nxt;
    logic [3:0]       r_match_cnt, w_match_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge, w_match, w_sat;
    logic             w_report, w_timeout, w_set_mismatch, w_overflow;

    blink_edge_detect #(
        .PREV_RST (1'b1)
    ) u_edge (
        .clk        (clk),
        .rstbtn     (rstbtn),
        .blink_in   (blink_in),
        .blink_edge (w_edge)
    );

    // Intervals below 2 are unmeasurable, so such expectations never match.
    assign w_match = (r_cnt == exp_interval) && (exp_interval > CNT_W'(1));
    assign w_sat   = (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (rstbtn) begin
            r_state     <= IDLE;
            r_match_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_match_nxt    = r_match_cnt;
        w_report       = 1'b0;
        w_timeout      = 1'b0;
        w_set_mismatch = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt = ARMED;
                    w_match_nxt = 4'd0;
                end
            end
            ARMED: begin
                if (w_edge) begin
                    w_report = 1'b1;
                    if (w_match) begin
                        w_match_nxt = r_match_cnt + 4'd1;
                        if (r_match_cnt + 4'd1 == c_lock) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        w_match_nxt = 4'd0;
                    end
                end else if (w_sat) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                    w_match_nxt = 4'd0;
                end
            end
            LOCKED: begin
                if (w_edge) begin
                    w_report = 1'b1;
                    if (!w_match) begin
                        w_set_mismatch = 1'b1;
                        w_match_nxt    = 4'd0;
                        w_state_nxt    = ARMED;
                    end
                end else if (w_sat) begin
                    w_timeout      = 1'b1;
                    w_set_mismatch = 1'b1;
                    w_state_nxt    = IDLE;
                    w_match_nxt    = 4'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_match_nxt = 4'd0;
            end
        endcase
    end

    // An edge landing on a saturated count still reports, but flags overflow.
    assign w_overflow = w_timeout | (w_report & w_sat);

    always_ff @(posedge clk) begin
        if (rstbtn) begin
            r_cnt          <= '0;
            interval_out   <= '0;
            interval_valid <= 1'b0;
            mismatch       <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (w_edge) begin
                r_cnt <= CNT_W'(1);
            end else if (!w_sat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_report) begin
                interval_out <= r_cnt;
            end
            interval_valid <= w_report;
            overflow       <= w_overflow;
            mismatch       <= mismatch | w_set_mismatch;
        end
    end

    assign locked = (r_state == LOCKED);

`ifdef BLINK_MONITOR_STATS_EN
    logic [CNT_W-1:0] r_min, r_max;

    always_ff @(posedge clk) begin
        if (rstbtn) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_report) begin
            if (r_cnt < r_min) begin
                r_min <= r_cnt;
            end
            if (r_cnt > r_max) begin
                r_max <= r_cnt;
            end
        end
    end

    assign min_interval = r_min;
    assign max_interval = r_max;
`else
    assign min_interval = '1;
    assign max_interval = '0;
`endif

endmodule : blink_monitor
`default_nettype wire

// File: tb/tb_blink_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_blink_monitor
// Purpose  : Directed self-checking bench for blink_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blink_monitor;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rstbtn;
    logic             blink_in;
    logic [CNT_W-1:0] exp_interval;
    logic [CNT_W-1:0] interval_out;
    logic             interval_valid;
    logic             locked;
    logic             mismatch;
    logic             overflow;
    logic [CNT_W-1:0] min_interval;
    logic [CNT_W-1:0] max_interval;

    int n_checks = 0;
    int n_errors = 0;

    blink_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (3)
    ) dut (
        .clk            (clk),
        .rstbtn         (rstbtn),
        .blink_in       (blink_in),
        .exp_interval   (exp_interval),
        .interval_out   (interval_out),
        .interval_valid (interval_valid),
        .locked         (locked),
        .mismatch       (mismatch),
        .overflow       (overflow),
        .min_interval   (min_interval),
        .max_interval   (max_interval)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle high pulse; outputs for that edge are visible on return.
    task automatic edge_tick();
        blink_in = 1'b1;
        tick();
        blink_in = 1'b0;
    endtask

    task automatic period_edge(input int p);
        repeat (p - 1) tick();
        edge_tick();
    endtask

    task automatic do_reset();
        rstbtn   = 1'b1;
        blink_in = 1'b0;
        tick();
        tick();
        rstbtn = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_count;
        int ov_at;
        int valid_seen;

        exp_interval = 8'd11;
        do_reset();
        check_val("rst_interval_out", 32'(interval_out), 0);
        check_val("rst_valid", 32'(interval_valid), 0);
        check_val("rst_locked", 32'(locked), 0);
        check_val("rst_mismatch", 32'(mismatch), 0);
        check_val("rst_overflow", 32'(overflow), 0);
        check_val("rst_min", 32'(min_interval), 255);
        check_val("rst_max", 32'(max_interval), 0);

        // Period 11 locks on the fourth edge.
        edge_tick();
        check_val("p11_first_valid", 32'(interval_valid), 0);
        period_edge(11);
        check_val("p11_e2_valid", 32'(interval_valid), 1);
        check_val("p11_e2_interval", 32'(interval_out), 11);
        check_val("p11_e2_locked", 32'(locked), 0);
        period_edge(11);
        check_val("p11_e3_locked", 32'(locked), 0);
        period_edge(11);
        check_val("p11_e4_valid", 32'(interval_valid), 1);
        check_val("p11_e4_interval", 32'(interval_out), 11);
        check_val("p11_e4_locked", 32'(locked), 1);
        check_val("p11_e4_mismatch", 32'(mismatch), 0);
        tick();
        check_val("p11_valid_strobe", 32'(interval_valid), 0);
        check_val("p11_hold_locked", 32'(locked), 1);

        // Reset pulse while locked, coinciding with a rising edge.
        repeat (3) tick();
        blink_in = 1'b1;
        rstbtn   = 1'b1;
        tick();
        rstbtn   = 1'b0;
        blink_in = 1'b0;
        check_val("lrst_interval_out", 32'(interval_out), 0);
        check_val("lrst_valid", 32'(interval_valid), 0);
        check_val("lrst_locked", 32'(locked), 0);
        check_val("lrst_mismatch", 32'(mismatch), 0);
        check_val("lrst_overflow", 32'(overflow), 0);
        tick();

        // Lock at 6, break with a 9 gap, then re-lock.
        exp_interval = 8'd6;
        edge_tick();
        repeat (3) period_edge(6);
        check_val("p6_locked", 32'(locked), 1);
        period_edge(9);
        check_val("gap9_interval", 32'(interval_out), 9);
        check_val("gap9_valid", 32'(interval_valid), 1);
        check_val("gap9_locked", 32'(locked), 0);
        check_val("gap9_mismatch", 32'(mismatch), 1);
        period_edge(6);
        period_edge(6);
        check_val("relock_e2_locked", 32'(locked), 0);
        period_edge(6);
        check_val("relock_locked", 32'(locked), 1);
        check_val("relock_mismatch", 32'(mismatch), 1);

        // Timeout from LOCKED after a long low stretch.
        ov_count   = 0;
        ov_at      = 0;
        valid_seen = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (overflow) begin
                ov_count++;
                ov_at = i;
            end
            if (interval_valid) valid_seen++;
        end
        check_val("to_overflow_count", 32'(ov_count), 1);
        check_val("to_overflow_at", 32'(ov_at), 255);
        check_val("to_valid_seen", 32'(valid_seen), 0);
        check_val("to_locked", 32'(locked), 0);
        check_val("to_mismatch", 32'(mismatch), 1);
        edge_tick();
        check_val("to_next_edge_valid", 32'(interval_valid), 0);

        // Level held high through reset release is not an edge.
        rstbtn   = 1'b1;
        blink_in = 1'b1;
        tick();
        tick();
        rstbtn = 1'b0;
        repeat (5) tick();
        blink_in = 1'b0;
        repeat (5) tick();
        edge_tick();
        check_val("hi_rst_first_valid", 32'(interval_valid), 0);
        period_edge(7);
        check_val("hi_rst_second_valid", 32'(interval_valid), 1);
        check_val("hi_rst_interval", 32'(interval_out), 7);

        // Stats over intervals 7, 4, 12 with a never-matching expectation.
        do_reset();
        exp_interval = 8'd0;
        edge_tick();
        period_edge(7);
        period_edge(4);
        period_edge(12);
        check_val("stats_interval", 32'(interval_out), 12);
        check_val("stats_locked", 32'(locked), 0);
`ifdef BLINK_MONITOR_STATS_EN
        check_val("stats_min", 32'(min_interval), 4);
        check_val("stats_max", 32'(max_interval), 12);
`else
        check_val("stats_min", 32'(min_interval), 255);
        check_val("stats_max", 32'(max_interval), 0);
`endif

        // Edge landing exactly on a saturated count: reported, overflow, no timeout.
        exp_interval = 8'd255;
        period_edge(255);
        check_val("sat_edge_valid", 32'(interval_valid), 1);
        check_val("sat_edge_interval", 32'(interval_out), 255);
        check_val("sat_edge_overflow", 32'(overflow), 1);
        period_edge(255);
        check_val("sat_edge2_valid", 32'(interval_valid), 1);
        check_val("sat_edge2_overflow", 32'(overflow), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_blink_monitor
`default_nettype wire
